// File: rtl/sync_timing_pkg.sv
// Shared timing constants and enumerations for the PAL 576i sync regenerator.
// Defaults describe an 81 MHz pixel clock; instances may override them.
package sync_timing_pkg;

  typedef enum logic [1:0] {
    SEARCH,
    ACQUIRE,
    LOCKED
  } seqState_e;

  typedef enum logic [1:0] {
    PAR_NONE,
    PAR_ODD,
    PAR_EVEN
  } parity_e;

  localparam int LINE_PERIOD_DEF   = 5184;
  localparam int HALF_LINE_DEF     = 2592;
  localparam int HWIN_DEF          = 40;
  localparam int ACQUIRE_LINES_DEF = 8;
  localparam int MISS_MAX_DEF      = 16;
  localparam int BROAD_MIN_DEF     = 2000;
  localparam int PARITY_TOL_DEF    = 400;

  localparam logic [9:0] FRAME_LINES        = 10'd625;
  localparam logic [9:0] FIELD2_FIRST_LINE  = 10'd313;
  localparam logic [2:0] FIELD_MIN_LINES    = 3'd4;

endpackage

// File: rtl/sync_line_sequencer_broad_pulse_detector.sv
// Measures csync low time, latches the flywheel phase at each falling edge and
// classifies long (broad) pulses by the phase at which they began.
module broad_pulse_detector
  import sync_timing_pkg::*;
#(
  parameter int LINE_PERIOD = LINE_PERIOD_DEF,
  parameter int HALF_LINE   = HALF_LINE_DEF,
  parameter int BROAD_MIN   = BROAD_MIN_DEF,
  parameter int PARITY_TOL  = PARITY_TOL_DEF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        csync_i,
  input  logic [12:0] hPhase_i,
  output logic        broadValid_o,
  output parity_e     parity_o
);

  localparam logic [12:0] LP   = 13'(LINE_PERIOD);
  localparam logic [12:0] HL   = 13'(HALF_LINE);
  localparam logic [12:0] TOL  = 13'(PARITY_TOL);
  localparam logic [11:0] BMIN = 12'(BROAD_MIN);

  logic        csyncPrev_q;
  logic [11:0] lowCnt_q, lowCnt_d;
  logic [12:0] fallPhase_q, fallPhase_d;

  always_comb begin
    lowCnt_d    = lowCnt_q;
    fallPhase_d = fallPhase_q;
    if (csync_i) begin
      lowCnt_d = '0;
    end else if (lowCnt_q != 12'hFFF) begin
      lowCnt_d = lowCnt_q + 12'd1;
    end
    if (csyncPrev_q && !csync_i) begin
      fallPhase_d = hPhase_i;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      csyncPrev_q <= 1'b1;
      lowCnt_q    <= '0;
      fallPhase_q <= '0;
    end else begin
      csyncPrev_q <= csync_i;
      lowCnt_q    <= lowCnt_d;
      fallPhase_q <= fallPhase_d;
    end
  end

  // Strobe on the first high sample; the top registers it, giving one cycle latency.
  assign broadValid_o = !csyncPrev_q && csync_i && (lowCnt_q >= BMIN);

  always_comb begin
    parity_o = PAR_NONE;
    if ((fallPhase_q <= TOL) || (fallPhase_q >= LP - TOL)) begin
      parity_o = PAR_ODD;
    end else if ((fallPhase_q >= HL - TOL) && (fallPhase_q <= HL + TOL)) begin
      parity_o = PAR_EVEN;
    end
  end

endmodule

// File: rtl/sync_line_sequencer.sv
// Lock FSM with a flywheel line counter that coasts through missing hsyncs,
// plus field identification from broad pulses and frame line numbering.
module sync_line_sequencer
  import sync_timing_pkg::*;
#(
  parameter int LINE_PERIOD   = LINE_PERIOD_DEF,
  parameter int HALF_LINE     = HALF_LINE_DEF,
  parameter int HWIN          = HWIN_DEF,
  parameter int ACQUIRE_LINES = ACQUIRE_LINES_DEF,
  parameter int MISS_MAX      = MISS_MAX_DEF,
  parameter int BROAD_MIN     = BROAD_MIN_DEF,
  parameter int PARITY_TOL    = PARITY_TOL_DEF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        csync,
  input  logic        hsync_in,
  output logic        line_start,
  output logic        field_start,
  output logic        field_odd,
  output logic [9:0]  line_num,
  output logic [12:0] h_phase,
  output logic        h_locked,
  output logic        v_locked
);

  localparam logic [12:0] LP        = 13'(LINE_PERIOD);
  localparam logic [12:0] HW        = 13'(HWIN);
  localparam logic [7:0]  AL        = 8'(ACQUIRE_LINES);
  localparam logic [7:0]  MM        = 8'(MISS_MAX);
  localparam logic [12:0] PHASE_MAX = 13'h1FFF;

  seqState_e   state_q, state_d;
  logic [12:0] hPhase_q, hPhase_d;
  logic [7:0]  good_q, good_d;
  logic [7:0]  miss_q, miss_d;
  logic        seen_q, seen_d;
  logic        lineStart_q, lineStart_d;
  logic        fieldStart_q, fieldStart_d;
  logic        fieldOdd_q, fieldOdd_d;
  logic        vLocked_q, vLocked_d;
  logic [9:0]  lineNum_q, lineNum_d;
  logic [2:0]  sinceBroad_q, sinceBroad_d;

  logic        broadValid;
  parity_e     parity;
  logic        accept;
  logic        lockLost;
  logic        inWindow;
  logic [12:0] phaseSat;

  broad_pulse_detector #(
    .LINE_PERIOD (LINE_PERIOD),
    .HALF_LINE   (HALF_LINE),
    .BROAD_MIN   (BROAD_MIN),
    .PARITY_TOL  (PARITY_TOL)
  ) uBroad (
    .clk          (clk),
    .rst_n        (rst_n),
    .csync_i      (csync),
    .hPhase_i     (hPhase_q),
    .broadValid_o (broadValid),
    .parity_o     (parity)
  );

  assign phaseSat = (hPhase_q == PHASE_MAX) ? hPhase_q : hPhase_q + 13'd1;
  assign inWindow = (hPhase_q >= LP - HW) && (hPhase_q <= LP + HW);

  always_comb begin
    state_d      = state_q;
    hPhase_d     = hPhase_q;
    good_d       = good_q;
    miss_d       = miss_q;
    seen_d       = seen_q;
    lineStart_d  = 1'b0;
    fieldStart_d = 1'b0;
    fieldOdd_d   = fieldOdd_q;
    vLocked_d    = vLocked_q;
    lineNum_d    = lineNum_q;
    sinceBroad_d = sinceBroad_q;
    accept       = 1'b0;
    lockLost     = 1'b0;

    case (state_q)
      SEARCH: begin
        hPhase_d = phaseSat;
        if (hsync_in) begin
          hPhase_d = '0;
          good_d   = 8'd1;
          state_d  = ACQUIRE;
        end
      end
      ACQUIRE: begin
        hPhase_d = phaseSat;
        if (hsync_in) begin
          hPhase_d = '0;
          if (inWindow) begin
            good_d = good_q + 8'd1;
            if (good_d == AL) begin
              state_d     = LOCKED;
              lineStart_d = 1'b1;
              seen_d      = 1'b1;
              miss_d      = '0;
            end
          end else begin
            good_d = 8'd1;
          end
        end else if (hPhase_q > LP + HW) begin
          state_d = SEARCH;
        end
      end
      LOCKED: begin
        hPhase_d    = (hPhase_q == LP - 13'd1) ? '0 : hPhase_q + 13'd1;
        lineStart_d = (hPhase_q == LP - 13'd1);
        // An early hsync absorbs the wrap; a late one follows a strobe already sent.
        if (hsync_in && (hPhase_q >= LP - HW)) begin
          accept      = 1'b1;
          lineStart_d = 1'b1;
        end else if (hsync_in && (hPhase_q <= HW)) begin
          accept = 1'b1;
        end
        if (accept) begin
          hPhase_d = '0;
          seen_d   = 1'b1;
          miss_d   = '0;
        end else if (hPhase_q == HW + 13'd1) begin
          seen_d = 1'b0;
          if (!seen_q) begin
            miss_d = miss_q + 8'd1;
          end
        end
        if (miss_d == MM) begin
          lockLost = 1'b1;
          state_d  = SEARCH;
        end
      end
      default: state_d = SEARCH;
    endcase

    if (lineStart_d) begin
      lineNum_d = (lineNum_q == FRAME_LINES) ? 10'd1 : lineNum_q + 10'd1;
      if (sinceBroad_q != FIELD_MIN_LINES) begin
        sinceBroad_d = sinceBroad_q + 3'd1;
      end
    end

    // Only the first broad pulse of a vertical interval may set field parity.
    if (broadValid) begin
      sinceBroad_d = '0;
      if ((state_q == LOCKED) && (sinceBroad_q == FIELD_MIN_LINES) && (parity != PAR_NONE)) begin
        fieldStart_d = 1'b1;
        vLocked_d    = 1'b1;
        fieldOdd_d   = (parity == PAR_ODD);
        lineNum_d    = (parity == PAR_ODD) ? 10'd1 : FIELD2_FIRST_LINE;
      end
    end

    if (lockLost) begin
      vLocked_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= SEARCH;
      hPhase_q     <= '0;
      good_q       <= '0;
      miss_q       <= '0;
      seen_q       <= 1'b0;
      lineStart_q  <= 1'b0;
      fieldStart_q <= 1'b0;
      fieldOdd_q   <= 1'b0;
      vLocked_q    <= 1'b0;
      lineNum_q    <= 10'd1;
      sinceBroad_q <= '0;
    end else begin
      state_q      <= state_d;
      hPhase_q     <= hPhase_d;
      good_q       <= good_d;
      miss_q       <= miss_d;
      seen_q       <= seen_d;
      lineStart_q  <= lineStart_d;
      fieldStart_q <= fieldStart_d;
      fieldOdd_q   <= fieldOdd_d;
      vLocked_q    <= vLocked_d;
      lineNum_q    <= lineNum_d;
      sinceBroad_q <= sinceBroad_d;
    end
  end

  assign line_start  = lineStart_q;
  assign field_start = fieldStart_q;
  assign field_odd   = fieldOdd_q;
  assign line_num    = lineNum_q;
  assign h_phase     = hPhase_q;
  assign h_locked    = (state_q == LOCKED);
  assign v_locked    = vLocked_q;

endmodule

// File: doc/sync_line_sequencer.md
# sync_line_sequencer

Line/field timing controller for the PAL 576i sync regenerator. It consumes the accepted hsync pulse stream and the raw composite sync, then runs a lock state machine with a flywheel line counter that coasts through missing or rejected pulses. It classifies broad (vertical) pulses to identify field parity and emits a regenerated line strobe, frame line number and lock flags to the downstream video timing logic. It sits directly after the csync edge/hsync/vsync extraction stage, in the 81 MHz domain.

## Interface
- LINE_PERIOD, 5184: clocks per line (64 us at 81 MHz).
- HALF_LINE, 2592: clocks per half line.
- HWIN, 40: ± acceptance window around expected hsync, clocks.
- ACQUIRE_LINES, 8: consecutive in-window hsyncs needed to lock.
- MISS_MAX, 16: consecutive missed lines before lock is dropped.
- BROAD_MIN, 2000: minimum csync low time, clocks, that classifies a pulse as broad.
- PARITY_TOL, 400: tolerance, clocks, for broad-pulse phase classification.
- clk  in  1  81 MHz clock; the only clock.
- rst_n  in  1  asynchronous active-low reset.
- csync  in  1  composite sync level, active low.
- hsync_in  in  1  single-cycle accepted hsync pulse.
- line_start  out  1  single-cycle regenerated line strobe.
- field_start  out  1  single-cycle strobe on field identification.
- field_odd  out  1  1 = field 1 (lines 1–312), 0 = field 2.
- line_num  out  10  frame line number, 1..625.
- h_phase  out  13  flywheel position, 0..LINE_PERIOD-1.
- h_locked  out  1  FSM in LOCKED.
- v_locked  out  1  field parity established since the last lock.

## Operation
- FSM states: SEARCH, ACQUIRE, LOCKED. Reset state is SEARCH.
- All outputs reset to 0, except line_num, which resets to 1.
- SEARCH:
  - On hsync_in: h_phase←0, good←1, go to ACQUIRE.
- ACQUIRE: h_phase free-runs without wrapping, saturating at 8191.
  - On hsync_in with |h_phase−LINE_PERIOD| ≤ HWIN: good++, h_phase←0.
  - On any other hsync_in: good←1, h_phase←0.
  - If h_phase > LINE_PERIOD+HWIN: go to SEARCH.
  - When good reaches ACQUIRE_LINES: go to LOCKED and assert line_start on that cycle.
  - No line_start is emitted in SEARCH or ACQUIRE except on that transition cycle.
- LOCKED:
  - h_phase wraps LINE_PERIOD-1→0 and asserts line_start at each wrap.
  - hsync_in with h_phase ≥ LINE_PERIOD−HWIN (early): accept, h_phase←0, assert line_start now. The wrap is thereby absorbed, so there is no double strobe.
  - hsync_in with h_phase ≤ HWIN (late, strobe already sent): accept, h_phase←0, no extra strobe.
  - hsync_in outside the window is ignored.
  - Accepting an hsync sets the seen flag and clears miss.
  - At h_phase == HWIN+1, with no re-phase on that cycle: if seen is clear, miss++. Then clear seen.
  - When miss reaches MISS_MAX: go to SEARCH, h_locked←0, v_locked←0.
- Line numbering: line_num increments on every line_start and wraps 625→1.
- Broad pulse detection:
  - Low counter counts while csync=0, saturating at 4095, and clears on csync=1.
  - On a csync falling edge, latch fall_phase←h_phase.
  - On the csync rising edge: the pulse is broad if the count ≥ BROAD_MIN.
- Field identification (LOCKED only). It applies to the first broad pulse after ≥4 line_starts with no broad pulse:
  - fall_phase ≤ PARITY_TOL or ≥ LINE_PERIOD−PARITY_TOL: field 1. line_num←1 (if the pulse began just before the wrap, the line_start that already occurred is counted as line 1). field_odd←1.
  - |fall_phase−HALF_LINE| ≤ PARITY_TOL: field 2. line_num←313, field_odd←0.
  - Either case: pulse field_start and set v_locked.
  - Any other phase: the pulse is ignored.
  - Broad pulses in SEARCH or ACQUIRE are ignored.
- Simultaneous events:
  - Counter wrap and in-window hsync on the same cycle produce one line_start.
  - field_start coinciding with line_start: the field load overrides the increment.

## Timing
- Output latency is one register stage. All outputs are registered.
- line_start is asserted in the cycle after the accepting hsync_in, or the cycle after wrap.
- field_start and the line_num load occur 1 cycle after the csync rising edge that ends the first broad pulse.
- Asynchronous reset mid-operation clears all state immediately. Operation restarts from SEARCH on the first clock after release.

## Structure
- Shared package sync_timing_pkg holds:
  - the state enum {SEARCH, ACQUIRE, LOCKED};
  - default constants for the line period, half line, and 625/313 line counts.
- One sub-module, broad_pulse_detector: the low-time counter, the fall_phase latch and the broad/parity classification. It outputs a single-cycle broad_valid strobe plus parity.

## Test plan
- Clean hsync every 5184 clocks → h_locked rises with the 8th pulse; line_start period is exactly 5184.
- Locked, hsync shifted +30 clocks once → one line_start only; h_phase re-phased; miss stays 0.
- Locked, hsync removed for 15 lines → line_start continues every 5184 clocks, still locked. Removed for 16 lines → h_locked=0, v_locked=0, state SEARCH.
- Locked, csync low 2200 clocks starting at h_phase=0 → field_start, field_odd=1, line_num=1. Next line_start → line_num=2.
- Locked, broad pulse starting at h_phase=2592 → field_odd=0, line_num=313. 313 line_starts later line_num wraps 625→1.
- rst_n asserted mid-field → all outputs at reset values immediately. Relock requires ACQUIRE_LINES pulses again.
